// File: rtl/peripheral_pkg.sv
// Shared types and defaults for the debounced enter-key byte sequencer.
package peripheral_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_NUM_BYTES       = 8;
  localparam int INDEX_W                 = 4;

  typedef enum logic [1:0] {
    RELEASE,
    ARMED,
    PRESS,
    FIRE
  } state_e;

endpackage

// File: rtl/peripheral_sync2.sv
// Two-flop synchronizer bringing the raw pushbutton level into the clk domain.
module peripheral_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments make meta_q and sync_q a real two-stage
  // shift; blocking ones would collapse them into a single flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/peripheral_enterseq.sv
// Debounced enter key: one enterpulse per accepted press, stepping a byte
// index from 0 up to NUM_BYTES, then holding with operands_ready set.
module peripheral_enterseq
  import peripheral_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int NUM_BYTES       = DEFAULT_NUM_BYTES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enter_btn,
  input  logic               clear,
  output logic               enterpulse,
  output logic [INDEX_W-1:0] datainput_i,
  output logic               operands_ready
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [INDEX_W-1:0] IDX_LAST = INDEX_W'(NUM_BYTES - 1);

  logic               btn_s;
  state_e             state_q;
  logic [CNT_W-1:0]   count_q;
  logic               pulse_q;
  logic [INDEX_W-1:0] idx_q;
  logic               ready_q;

  peripheral_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (enter_btn),
    .q_o   (btn_s)
  );

  // The counter only ever runs up to CNT_LAST before the state changes, so
  // it cannot wrap; PRESS refuses to reach FIRE once the sequence is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RELEASE;
      count_q <= '0;
      pulse_q <= 1'b0;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else if (clear) begin
      state_q <= RELEASE;
      count_q <= '0;
      pulse_q <= 1'b0;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        RELEASE: begin
          if (btn_s) begin
            count_q <= '0;
          end else if (count_q == CNT_LAST) begin
            state_q <= ARMED;
            count_q <= '0;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        ARMED: begin
          if (btn_s) begin
            state_q <= PRESS;
            count_q <= '0;
          end
        end
        PRESS: begin
          if (!btn_s) begin
            state_q <= ARMED;
            count_q <= '0;
          end else if (count_q == CNT_LAST) begin
            count_q <= '0;
            if (!ready_q) begin
              state_q <= FIRE;
              pulse_q <= 1'b1;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        FIRE: begin
          state_q <= RELEASE;
          count_q <= '0;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) ready_q <= 1'b1;
        end
        default: begin
          state_q <= RELEASE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign enterpulse     = pulse_q;
  assign datainput_i    = idx_q;
  assign operands_ready = ready_q;

endmodule

// File: tb/tb_peripheral_enterseq.sv
// Scoreboard bench for peripheral_enterseq with DEBOUNCE_CYCLES=4, NUM_BYTES=8.
module tb_peripheral_enterseq;

  localparam int DB = 4;
  localparam int NB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enter_btn = 1'b0;
  logic       clear = 1'b0;
  logic       enterpulse;
  logic [3:0] datainput_i;
  logic       operands_ready;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  logic [3:0] exp_q[$];
  logic [3:0] sb_exp;
  logic [3:0] model_idx = 4'd0;
  logic       model_ready = 1'b0;

  peripheral_enterseq #(
    .DEBOUNCE_CYCLES (DB),
    .NUM_BYTES       (NB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enter_btn      (enter_btn),
    .clear          (clear),
    .enterpulse     (enterpulse),
    .datainput_i    (datainput_i),
    .operands_ready (operands_ready)
  );

  always #5 clk = ~clk;

  // Every pulse must match the next expected index pushed at press time.
  always @(negedge clk) begin
    if (reset && enterpulse) begin
      pulse_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got pulse at index %0d, required no pulse", datainput_i);
      end else begin
        sb_exp = exp_q.pop_front();
        if (datainput_i !== sb_exp) begin
          errors++;
          $display("FAIL pulse_index: got %0d required %0d", datainput_i, sb_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_fire();
    if (!model_ready) begin
      exp_q.push_back(model_idx);
      model_idx = model_idx + 4'd1;
      if (model_idx == 4'(NB)) model_ready = 1'b1;
    end
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    enter_btn = 1'b1;
    expect_fire();
    repeat (hold) @(negedge clk);
    enter_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (enterpulse !== 1'b0) begin
      errors++; $display("FAIL reset_pulse: got %b required 0", enterpulse);
    end
    checks++;
    if (datainput_i !== 4'd0) begin
      errors++; $display("FAIL reset_index: got %0d required 0", datainput_i);
    end
    checks++;
    if (operands_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b required 0", operands_ready);
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int p0;
    p0 = pulse_cnt;
    @(negedge clk);
    enter_btn = 1'b1;
    expect_fire();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (enterpulse !== 1'b0) begin
      errors++; $display("FAIL clean_early: got %b after edge 5 required 0", enterpulse);
    end
    @(posedge clk);
    #1;
    checks++;
    if (enterpulse !== 1'b1 || datainput_i !== 4'd0) begin
      errors++;
      $display("FAIL clean_fire: got pulse=%b idx=%0d required pulse=1 idx=0", enterpulse, datainput_i);
    end
    @(posedge clk);
    #1;
    checks++;
    if (enterpulse !== 1'b0 || datainput_i !== 4'd1 || operands_ready !== 1'b0) begin
      errors++;
      $display("FAIL clean_after: got pulse=%b idx=%0d ready=%b required 0 1 0",
               enterpulse, datainput_i, operands_ready);
    end
    repeat (12) @(negedge clk);
    enter_btn = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++; $display("FAIL clean_count: got %0d pulses required 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_cnt;
    @(negedge clk) enter_btn = 1'b1;
    @(negedge clk) enter_btn = 1'b0;
    @(negedge clk) enter_btn = 1'b1;
    @(negedge clk) enter_btn = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (pulse_cnt - p0 !== 0) begin
      errors++; $display("FAIL bounce_count: got %0d pulses required 0", pulse_cnt - p0);
    end
    checks++;
    if (datainput_i !== model_idx) begin
      errors++; $display("FAIL bounce_index: got %0d required %0d", datainput_i, model_idx);
    end
  endtask

  task automatic test_fill();
    int p0;
    while (!model_ready) begin
      press(10);
      checks++;
      if (datainput_i !== model_idx) begin
        errors++; $display("FAIL fill_index: got %0d required %0d", datainput_i, model_idx);
      end
    end
    checks++;
    if (datainput_i !== 4'(NB) || operands_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_done: got idx=%0d ready=%b required idx=%0d ready=1",
               datainput_i, operands_ready, NB);
    end
    p0 = pulse_cnt;
    press(10);
    checks++;
    if (pulse_cnt - p0 !== 0 || datainput_i !== 4'(NB) || operands_ready !== 1'b1) begin
      errors++;
      $display("FAIL ninth_press: got pulses=%0d idx=%0d ready=%b required 0 %0d 1",
               pulse_cnt - p0, datainput_i, operands_ready, NB);
    end
  endtask

  task automatic test_clear();
    int p0;
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (datainput_i !== 4'd0 || operands_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: got idx=%0d ready=%b required idx=0 ready=0", datainput_i, operands_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    model_idx = 4'd0;
    model_ready = 1'b0;
    repeat (8) @(negedge clk);
    p0 = pulse_cnt;
    press(10);
    checks++;
    if (pulse_cnt - p0 !== 1 || datainput_i !== 4'd1) begin
      errors++;
      $display("FAIL clear_repress: got pulses=%0d idx=%0d required 1 1", pulse_cnt - p0, datainput_i);
    end
  endtask

  task automatic test_reset_mid_press();
    int p0;
    @(negedge clk);
    enter_btn = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (enterpulse !== 1'b0 || datainput_i !== 4'd0 || operands_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got pulse=%b idx=%0d ready=%b required 0 0 0",
               enterpulse, datainput_i, operands_ready);
    end
    model_idx = 4'd0;
    model_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    p0 = pulse_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (pulse_cnt - p0 !== 0) begin
      errors++; $display("FAIL held_after_reset: got %0d pulses required 0", pulse_cnt - p0);
    end
    enter_btn = 1'b0;
    repeat (12) @(negedge clk);
    press(10);
    checks++;
    if (pulse_cnt - p0 !== 1 || datainput_i !== 4'd1) begin
      errors++;
      $display("FAIL reset_repress: got pulses=%0d idx=%0d required 1 1", pulse_cnt - p0, datainput_i);
    end
  endtask

  task automatic test_clear_during_fire();
    int p0;
    p0 = pulse_cnt;
    @(negedge clk);
    enter_btn = 1'b1;
    expect_fire();
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (enterpulse !== 1'b1) begin
      errors++; $display("FAIL fire_before_clear: got %b required 1", enterpulse);
    end
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (enterpulse !== 1'b0 || datainput_i !== 4'd0 || operands_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_on_fire: got pulse=%b idx=%0d ready=%b required 0 0 0",
               enterpulse, datainput_i, operands_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    model_idx = 4'd0;
    model_ready = 1'b0;
    repeat (10) @(negedge clk);
    enter_btn = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++; $display("FAIL clear_fire_count: got %0d pulses required 1", pulse_cnt - p0);
    end
    press(10);
    checks++;
    if (pulse_cnt - p0 !== 2 || datainput_i !== 4'd1) begin
      errors++;
      $display("FAIL post_clear_press: got pulses=%0d idx=%0d required 2 1", pulse_cnt - p0, datainput_i);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_fill();
    test_clear();
    test_reset_mid_press();
    test_clear_during_fire();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_pulses: got %0d outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_enterseq.md
PERIPHERAL_ENTERSEQ -- requirements
Module: peripheral_enterseq

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples required to accept a level (legal range 2..65535).
REQ-002 Parameter NUM_BYTES, default 8, number of operand bytes per sequence (legal range 1..15).
REQ-003 Port clk, input, 1, single clock for all logic.
REQ-004 Port reset, input, 1, asynchronous, active-low reset: assertion takes effect immediately, independent of clk.
REQ-005 Port enter_btn, input, 1, raw asynchronous pushbutton level, active-high, may bounce.
REQ-006 Port clear, input, 1, synchronous restart of the byte sequence, active-high.
REQ-007 Port enterpulse, output, 1, single-cycle strobe for one accepted press.
REQ-008 Port datainput_i, output, 4, index of the byte being entered (0..NUM_BYTES).
REQ-009 Port operands_ready, output, 1, high once NUM_BYTES pulses are issued.

Function
REQ-010 enter_btn SHALL pass through a two-flop synchronizer before use; the second flop output is btn_s.
REQ-011 The FSM SHALL have exactly four states: RELEASE, ARMED, PRESS and FIRE.
REQ-012 RELEASE: counter increments each cycle btn_s=0 and clears to 0 when btn_s=1; on count==DEBOUNCE_CYCLES-1 with btn_s=0, go to ARMED.
REQ-013 ARMED: btn_s=1 goes to PRESS with count=0; otherwise stay.
REQ-014 PRESS: btn_s=0 returns to ARMED (bounce rejected, no pulse); count increments while btn_s=1; on count==DEBOUNCE_CYCLES-1 with btn_s=1, go to FIRE if operands_ready=0, otherwise go to RELEASE.
REQ-015 FIRE SHALL last exactly one cycle, then go to RELEASE with count=0.
REQ-016 enterpulse SHALL be 1 exactly while the state is FIRE; it is a registered state decode with no combinational path from enter_btn.
REQ-017 datainput_i SHALL be stable during the enterpulse cycle and SHALL increment by 1 on the clock edge leaving FIRE.
REQ-018 operands_ready SHALL be set on the same edge at which datainput_i becomes NUM_BYTES.
REQ-019 With operands_ready=1, datainput_i SHALL hold at NUM_BYTES, no further pulses SHALL issue, and it never wraps.
REQ-020 Latency: for enter_btn held high from the edge it is first sampled (edge 0), enterpulse SHALL be high in the cycle following edge DEBOUNCE_CYCLES+2.
REQ-021 clear=1 SHALL on the next edge set datainput_i=0, operands_ready=0, state=RELEASE and count=0; a coincident FIRE pulse completes, but its index increment is discarded.
REQ-022 clear SHALL take priority over all FSM transitions; a button held through clear must be released and debounced before the next press is accepted.
REQ-023 Exactly one enterpulse SHALL issue per debounced press, however long the button is held.

Reset
REQ-024 While reset=0: state=RELEASE, count=0, synchronizer flops=0, enterpulse=0, datainput_i=0, operands_ready=0.
REQ-025 Reset asserted mid-debounce or during FIRE SHALL abort the operation with no pulse; after release, a button held high SHALL NOT fire until it is released and pressed again.

Structure
REQ-026 Package peripheral_pkg SHALL hold the FSM state enum typedef and the default DEBOUNCE_CYCLES and NUM_BYTES constants.
REQ-027 Sub-module peripheral_sync2 SHALL implement the two-flop synchronizer, reset by the same active-low asynchronous reset.
REQ-028 The counter width SHALL be $clog2(DEBOUNCE_CYCLES), and no count SHALL overflow.

Verification (DEBOUNCE_CYCLES=4, NUM_BYTES=8)
REQ-029 Clean press: btn high for 20 cycles from edge 0 -> single enterpulse in the cycle after edge 6, datainput_i=0 during the pulse, then 1.
REQ-030 Bounce: btn toggles 1,0,1,0 on successive cycles, then stays low -> no enterpulse, datainput_i unchanged.
REQ-031 Eight clean presses -> 8 pulses with datainput_i 0..7; after the 8th, datainput_i=8 and operands_ready=1; a 9th press -> no pulse, values held.
REQ-032 clear pulsed while operands_ready=1 and btn low -> next edge datainput_i=0, operands_ready=0; next press pulses with index 0.
REQ-033 Reset asserted (reset=0) mid-PRESS with btn held, then deasserted with btn still held -> no pulse until the btn is released for 4+ cycles and pressed again.
REQ-034 clear coincident with FIRE -> one enterpulse is seen, then datainput_i=0 and operands_ready=0.
